// File: rtl/spi_pkg.sv
// Shared types and constants for the two-port SPI arbiter slice.
package spi_pkg;

  localparam int NUM_PORTS = 2;

  // Device-class codes carried in address bits 24:20
  localparam logic [4:0] DEV_ADC = 5'b00001;
  localparam logic [4:0] DEV_DAC = 5'b00010;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_COMPLETE   = 3'd4
  } arb_state_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-port round-robin winner selection; last_owner remembers who completed most recently.
module spi_rr_arbiter
  import spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 update,
  input  logic                 owner,
  output logic                 any,
  output logic                 win
);

  logic last_owner_r;

  assign any = |req;

  // Winner select: a tie goes to the port that did not own the bus last
  always_comb begin
    if (req == 2'b11) begin
      win = ~last_owner_r;
    end else if (req[1]) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

  // Ownership history, seeded so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_r <= 1'b1;
    end else if (update) begin
      last_owner_r <= owner;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Two-port arbiter in front of a single SPI controller: grants one port, issues a
// single request pulse, tracks controller busy with a start window and a timeout.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [3:0]  START_WINDOW   = 4'd4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] we,
  input  logic [25:0]          addr0,
  input  logic [25:0]          addr1,
  input  logic [31:0]          wdata0,
  input  logic [31:0]          wdata1,
  output logic [NUM_PORTS-1:0] ack,
  output logic [NUM_PORTS-1:0] err,
  output logic [31:0]          rdata,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 spi_write_req,
  output logic                 spi_read_req,
  output logic [25:0]          spi_address,
  output logic [31:0]          spi_data_write,
  input  logic [31:0]          spi_data_read,
  input  logic                 spi_busy
);

  arb_state_t  state_r;
  logic        owner_r;
  logic [15:0] cnt_r;
  logic        arb_any_s;
  logic        arb_win_s;
  logic        arb_update_s;
  logic        timeout_s;
  logic        window_s;

  assign arb_update_s = (state_r == ST_COMPLETE);
  assign timeout_s    = ((cnt_r + 16'd1) == TIMEOUT_CYCLES);
  assign window_s     = (cnt_r == {12'd0, START_WINDOW});

  spi_rr_arbiter u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (arb_update_s),
    .owner  (owner_r),
    .any    (arb_any_s),
    .win    (arb_win_s)
  );

  // Transaction FSM; every output is registered so it is set on entry to the state it belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      owner_r        <= 1'b0;
      cnt_r          <= 16'd0;
      ack            <= 2'b00;
      err            <= 2'b00;
      grant          <= 2'b00;
      spi_write_req  <= 1'b0;
      spi_read_req   <= 1'b0;
      rdata          <= 32'd0;
      spi_address    <= 26'd0;
      spi_data_write <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_any_s && !spi_busy) begin
            owner_r        <= arb_win_s;
            grant          <= port_onehot(arb_win_s);
            spi_address    <= arb_win_s ? addr1 : addr0;
            spi_data_write <= arb_win_s ? wdata1 : wdata0;
            spi_write_req  <= we[arb_win_s];
            spi_read_req   <= ~we[arb_win_s];
            state_r        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          spi_write_req <= 1'b0;
          spi_read_req  <= 1'b0;
          cnt_r         <= 16'd0;
          state_r       <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (spi_busy) begin
            cnt_r   <= cnt_r + 16'd1;
            state_r <= ST_WAIT_DONE;
          end else if (window_s) begin
            // Controller never picked the request up; finish quietly
            ack     <= port_onehot(owner_r);
            state_r <= ST_COMPLETE;
          end else if (timeout_s) begin
            ack     <= port_onehot(owner_r);
            err     <= port_onehot(owner_r);
            state_r <= ST_COMPLETE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!spi_busy) begin
            rdata   <= spi_data_read;
            ack     <= port_onehot(owner_r);
            state_r <= ST_COMPLETE;
          end else if (timeout_s) begin
            ack     <= port_onehot(owner_r);
            err     <= port_onehot(owner_r);
            state_r <= ST_COMPLETE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_COMPLETE: begin
          ack     <= 2'b00;
          err     <= 2'b00;
          grant   <= 2'b00;
          state_r <= ST_IDLE;
        end
        default: begin
          ack           <= 2'b00;
          err           <= 2'b00;
          grant         <= 2'b00;
          spi_write_req <= 1'b0;
          spi_read_req  <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: reset values, an arbitration vector table, directed corner
// cases, and randomized traffic scored against a transaction-level model.
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam logic [25:0] ADDR_DAC = {1'b0, DEV_DAC, 20'h00003};
  localparam logic [25:0] ADDR_ADC = {1'b0, DEV_ADC, 20'h00201};

  logic        clk;
  logic        reset;
  logic [1:0]  req, we;
  logic [25:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  ack, err, grant;
  logic [31:0] rdata;
  logic        spi_write_req, spi_read_req;
  logic [25:0] spi_address;
  logic [31:0] spi_data_write;
  logic [31:0] spi_data_read = 32'd0;
  logic        spi_busy = 1'b0;

  spi_arbiter #(.TIMEOUT_CYCLES(16'd100), .START_WINDOW(4'd4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata), .grant(grant),
    .spi_write_req(spi_write_req), .spi_read_req(spi_read_req),
    .spi_address(spi_address), .spi_data_write(spi_data_write),
    .spi_data_read(spi_data_read), .spi_busy(spi_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI controller stand-in: after a request pulse, raise busy after sl_delay cycles for sl_len cycles
  bit          sl_never = 1'b1, sl_stuck = 1'b0, sl_kill = 1'b0, sl_active = 1'b0;
  int          sl_delay = 0, sl_len = 0, sl_cnt = 0;
  logic [31:0] sl_data = 32'd0;
  int          issue_cyc = 0, wr_pulses = 0, rd_pulses = 0, both_pulses = 0;

  always @(negedge clk) begin
    if (sl_kill) begin
      spi_busy  = 1'b0;
      sl_active = 1'b0;
    end else begin
      if (spi_write_req || spi_read_req) begin
        issue_cyc = cyc;
        if (spi_write_req) wr_pulses++;
        if (spi_read_req) rd_pulses++;
        if (spi_write_req && spi_read_req) both_pulses++;
        if (!sl_never) begin
          sl_active = 1'b1;
          sl_cnt    = 0;
        end
      end
      if (sl_active) begin
        if (sl_cnt == sl_delay) spi_busy = 1'b1;
        if (!sl_stuck && sl_cnt == sl_delay + sl_len) begin
          spi_busy      = 1'b0;
          spi_data_read = sl_data;
          sl_active     = 1'b0;
        end
        sl_cnt++;
      end
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic set_slave(input bit never, input bit stuck, input int d, input int l,
                           input logic [31:0] data);
    sl_never = never; sl_stuck = stuck; sl_delay = d; sl_len = l; sl_data = data;
  endtask

  task automatic kill_slave();
    sl_kill = 1'b1;
    repeat (2) @(negedge clk);
    sl_stuck = 1'b0;
    sl_kill  = 1'b0;
  endtask

  // Wait (bounded) for the next ack; optionally drop the acked port's request
  task automatic serve_one(input bit keep, output int port, output int lat,
                           output logic [1:0] ack_v, output logic [1:0] err_v,
                           output logic [1:0] gr_v);
    int n;
    n = 0;
    @(negedge clk);
    while (ack == 2'b00 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", {63'd0, ack != 2'b00}, 64'd1);
    ack_v = ack;
    err_v = err;
    gr_v  = grant;
    lat   = cyc - issue_cyc;
    port  = ack[1] ? 1 : 0;
    if (!keep && ack != 2'b00) req[port] = 1'b0;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    int         first;
    int         second;
  } arb_vec_t;

  arb_vec_t    tbl [8];
  int          port, lat, w0, r0, exp_port, exp_lat, exp_wr, exp_rd, model_last;
  logic [1:0]  ack_v, err_v, gr_v, pend;
  logic [31:0] tmp, model_rdata, cur_data;
  bit          cur_never, known;

  task automatic rand_slave();
    int d, l;
    cur_never = ($urandom_range(0, 2) == 0);
    d         = $urandom_range(0, 3);
    l         = $urandom_range(2, 12);
    cur_data  = $urandom;
    set_slave(cur_never, 1'b0, d, l, cur_data);
    exp_lat = cur_never ? 6 : d + l + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b11, 2'b01, 0, 1};
    tbl[1] = '{2'b01, 2'b00, 0, -1};
    tbl[2] = '{2'b11, 2'b10, 1, 0};
    tbl[3] = '{2'b10, 2'b10, 1, -1};
    tbl[4] = '{2'b10, 2'b00, 1, -1};
    tbl[5] = '{2'b11, 2'b11, 0, 1};
    tbl[6] = '{2'b01, 2'b01, 0, -1};
    tbl[7] = '{2'b11, 2'b00, 1, 0};

    reset = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = 26'd0; addr1 = 26'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {56'd0, ack, err, grant, spi_write_req, spi_read_req}, 64'd0);
    check("reset_rdata", {32'd0, rdata}, 64'd0);
    check("reset_addr", {38'd0, spi_address}, 64'd0);
    check("reset_wdata", {32'd0, spi_data_write}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Arbitration table, controller silent so every transaction takes the start-window path
    for (int i = 0; i < 8; i++) begin
      set_slave(1'b1, 1'b0, 0, 0, 32'd0);
      we = tbl[i].we; addr0 = ADDR_DAC; addr1 = ADDR_ADC;
      req = tbl[i].req;
      serve_one(1'b0, port, lat, ack_v, err_v, gr_v);
      check($sformatf("tbl%0d_first", i), port, tbl[i].first);
      check($sformatf("tbl%0d_grant", i), {62'd0, gr_v}, (tbl[i].first == 1) ? 64'd2 : 64'd1);
      check($sformatf("tbl%0d_lat", i), lat, 64'd6);
      check($sformatf("tbl%0d_err", i), {62'd0, err_v}, 64'd0);
      if (tbl[i].second >= 0) begin
        serve_one(1'b0, port, lat, ack_v, err_v, gr_v);
        check($sformatf("tbl%0d_second", i), port, tbl[i].second);
        check($sformatf("tbl%0d_lat2", i), lat, 64'd6);
      end
      repeat (2) @(negedge clk);
      check($sformatf("tbl%0d_idle_grant", i), {62'd0, grant}, 64'd0);
    end

    // Port 0 write, controller busy for 30 cycles
    set_slave(1'b0, 1'b0, 0, 30, 32'h1111_2222);
    we = 2'b01; addr0 = 26'h0100005; wdata0 = 32'h0000_00A5;
    w0 = wr_pulses; r0 = rd_pulses;
    req = 2'b01;
    serve_one(1'b0, port, lat, ack_v, err_v, gr_v);
    check("wr_ack", {62'd0, ack_v}, 64'd1);
    check("wr_err", {62'd0, err_v}, 64'd0);
    check("wr_lat", lat, 64'd31);
    check("wr_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd1, 32'd0});
    check("wr_addr", {38'd0, spi_address}, {38'd0, 26'h0100005});
    check("wr_data", {32'd0, spi_data_write}, 64'h0000_00A5);

    // Port 1 read with data returned at busy fall
    set_slave(1'b0, 1'b0, 1, 5, 32'h0000_003C);
    we = 2'b00; addr1 = 26'h0100201;
    w0 = wr_pulses; r0 = rd_pulses;
    req = 2'b10;
    serve_one(1'b0, port, lat, ack_v, err_v, gr_v);
    check("rd_ack", {62'd0, ack_v}, 64'd2);
    check("rd_rdata", {32'd0, rdata}, 64'h3C);
    check("rd_lat", lat, 64'd7);
    check("rd_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd0, 32'd1});

    // Both ports requesting continuously must alternate
    set_slave(1'b1, 1'b0, 0, 0, 32'd0);
    we = 2'b11;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      serve_one(1'b1, port, lat, ack_v, err_v, gr_v);
      check($sformatf("alt%0d_port", k), port, k % 2);
    end
    req = 2'b00;

    // DAC read: controller never goes busy
    set_slave(1'b1, 1'b0, 0, 0, 32'd0);
    we = 2'b00; addr0 = 26'h0200003;
    req = 2'b01;
    serve_one(1'b0, port, lat, ack_v, err_v, gr_v);
    check("dac_ack", {62'd0, ack_v}, 64'd1);
    check("dac_lat", lat, 64'd6);
    check("dac_err", {62'd0, err_v}, 64'd0);
    check("dac_rdata", {32'd0, rdata}, 64'h3C);

    // Busy stuck high: timeout after 100 cycles
    set_slave(1'b0, 1'b1, 0, 0, 32'hDEAD_BEEF);
    we = 2'b01;
    req = 2'b01;
    serve_one(1'b0, port, lat, ack_v, err_v, gr_v);
    check("to_ack", {62'd0, ack_v}, 64'd1);
    check("to_err", {62'd0, err_v}, 64'd1);
    check("to_rdata", {32'd0, rdata}, 64'h3C);
    check("to_lat_range", {63'd0, (lat >= 100 && lat <= 102)}, 64'd1);
    kill_slave();

    // Reset in WAIT_DONE abandons the transaction; held request is reissued afterwards
    set_slave(1'b0, 1'b1, 0, 0, 32'd0);
    we = 2'b00; addr0 = ADDR_ADC;
    req = 2'b01;
    repeat (6) @(negedge clk);
    check("rst_mid_grant", {62'd0, grant}, 64'd1);
    reset = 1'b1;
    sl_kill = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_ctrl", {56'd0, ack, err, grant, spi_write_req, spi_read_req}, 64'd0);
    set_slave(1'b1, 1'b0, 0, 0, 32'd0);
    w0 = wr_pulses; r0 = rd_pulses;
    reset = 1'b0;
    sl_kill = 1'b0;
    serve_one(1'b0, port, lat, ack_v, err_v, gr_v);
    check("rst_re_ack", {62'd0, ack_v}, 64'd1);
    check("rst_re_lat", lat, 64'd6);
    check("rst_re_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd0, 32'd1});

    // Randomized traffic against the transaction model
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rand_reset_rdata", {32'd0, rdata}, 64'd0);
    model_last = 1; model_rdata = 32'd0; known = 1'b1;
    exp_wr = wr_pulses; exp_rd = rd_pulses;
    for (int r = 0; r < 30; r++) begin
      pend = 2'($urandom_range(1, 3));
      tmp = $urandom; we = tmp[1:0];
      tmp = $urandom; addr0 = tmp[25:0];
      tmp = $urandom; addr1 = tmp[25:0];
      wdata0 = $urandom; wdata1 = $urandom;
      rand_slave();
      req = pend;
      while (pend != 2'b00) begin
        exp_port = (pend == 2'b11) ? (1 - model_last) : (pend[1] ? 1 : 0);
        if (we[exp_port]) exp_wr++;
        else exp_rd++;
        serve_one(1'b0, port, lat, ack_v, err_v, gr_v);
        check($sformatf("r%0d_port", r), port, exp_port);
        check($sformatf("r%0d_grant", r), {62'd0, gr_v}, (exp_port == 1) ? 64'd2 : 64'd1);
        check($sformatf("r%0d_lat", r), lat, exp_lat);
        check($sformatf("r%0d_err", r), {62'd0, err_v}, 64'd0);
        check($sformatf("r%0d_addr", r), {38'd0, spi_address},
              {38'd0, (exp_port == 1) ? addr1 : addr0});
        check($sformatf("r%0d_wdata", r), {32'd0, spi_data_write},
              {32'd0, (exp_port == 1) ? wdata1 : wdata0});
        check($sformatf("r%0d_pulses", r), {wr_pulses, rd_pulses}, {exp_wr, exp_rd});
        if (!cur_never) begin
          if (we[exp_port]) known = 1'b0;
          else begin
            model_rdata = cur_data;
            known = 1'b1;
          end
        end
        if (known) check($sformatf("r%0d_rdata", r), {32'd0, rdata}, {32'd0, model_rdata});
        model_last = exp_port;
        pend[exp_port] = 1'b0;
        if (pend != 2'b00) rand_slave();
      end
      repeat (2) @(negedge clk);
      check($sformatf("r%0d_idle_grant", r), {62'd0, grant}, 64'd0);
    end
    check("never_both_req", both_pulses, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
